// File: rtl/dmc_requester.sv
// Load/store initiator for the two-bank data memory controller.
// Queues requests in order, enforces turnaround beats, returns load data in issue order.
module dmc_requester #(
    parameter int QDEPTH = 4,
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_bank,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       mem_select,
    output logic       write_enable,
    output logic [7:0] add_ex,
    output logic [7:0] data_ex,
    input  logic [7:0] mem_rdata,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_bank,
    output logic [7:0] resp_addr
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic       write;
        logic       bank;
        logic [7:0] addr;
        logic [7:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {
        BEAT_HOLD,
        BEAT_TURN,
        BEAT_ISSUE
    } beat_t;

    entry_t        queue [QDEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          last_dir;
    logic          last_was_issue;
    beat_t         beat;
    logic          push;
    logic          pop;

    logic [RD_LAT:0] pipe_valid;
    logic [RD_LAT:0] pipe_bank;
    logic [7:0]      pipe_addr [RD_LAT+1];

    assign head      = queue[rd_ptr];
    assign req_ready = !rst && (count < CW'(QDEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (beat == BEAT_ISSUE);

    // A direction change right after an issued beat must repeat that beat once
    always_comb begin
        beat = BEAT_HOLD;
        if (count != '0) begin
            if ((head.write != last_dir) && last_was_issue) begin
                beat = BEAT_TURN;
            end else begin
                beat = BEAT_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            queue[wr_ptr] <= {req_write, req_bank, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            mem_select     <= 1'b0;
            write_enable   <= 1'b0;
            add_ex         <= '0;
            data_ex        <= '0;
            last_dir       <= 1'b0;
            last_was_issue <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + AW'(1);
                mem_select   <= head.bank;
                write_enable <= head.write;
                add_ex       <= head.addr;
                data_ex      <= head.wdata;
                last_dir     <= head.write;
            end
            count          <= count + CW'(push) - CW'(pop);
            last_was_issue <= pop;
        end
    end

    // Only issued reads are tracked; repeated read beats never respond
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_bank  <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_addr[i] <= '0;
            end
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_bank  <= 1'b0;
            resp_addr  <= '0;
        end else begin
            pipe_valid[0] <= pop && !head.write;
            pipe_bank[0]  <= head.bank;
            pipe_addr[0]  <= head.addr;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_bank[i]  <= pipe_bank[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
            resp_valid <= pipe_valid[RD_LAT];
            if (pipe_valid[RD_LAT]) begin
                resp_data <= mem_rdata;
                resp_bank <= pipe_bank[RD_LAT];
                resp_addr <= pipe_addr[RD_LAT];
            end
        end
    end

endmodule
